// File: rtl/lfsr_pkg.sv
// Shared types, constants and the feedback function for the 5-bit Fibonacci LFSR
// (taps x^5 + x^3 + 1, maximal length 31).
package lfsr_pkg;

  typedef logic [4:0] lfsr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

  localparam lfsr_t LFSR_RESET  = 5'b00001;
  localparam int    LFSR_PERIOD = 31;

  // New bit q[0]^q[2] enters at the MSB while the register shifts right.
  function automatic lfsr_t lfsr_next(input lfsr_t cur);
    return {cur[0] ^ cur[2], cur[4:1]};
  endfunction

endpackage

// File: rtl/lfsr_step_ctrl_if.sv
// Valid/ready output channel from the LFSR controller to the downstream
// consumer (modulation/sample stage). master = producer, slave = consumer.
interface lfsr_step_ctrl_if;
  import lfsr_pkg::*;

  lfsr_t q;
  logic  q_valid;
  logic  q_ready;

  modport master (
    output q,
    output q_valid,
    input  q_ready
  );

  modport slave (
    input  q,
    input  q_valid,
    output q_ready
  );

endinterface

// File: rtl/lfsr_step_ctrl_core.sv
// lfsr_core: the 5-bit LFSR state register with parallel load; load has
// priority over a step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter lfsr_t RESET_STATE = LFSR_RESET
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  load,
  input  lfsr_t load_val,
  output lfsr_t q
);

  lfsr_t q_q;

  // NOTE: sequential state is only ever updated with <= so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_STATE;
    end else if (load) begin
      q_q <= load_val;
    end else if (en) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// LFSR sequencing controller: run/pause FSM, tick divider, valid/ready output,
// period and overrun flags. Define LFSR_LOCKUP_RECOVER_EN to reject a zero seed.
module lfsr_step_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25_000_000,
  parameter int unsigned DIV_W       = $clog2(TICK_DIV),
  parameter lfsr_t       RESET_STATE = LFSR_RESET
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    seed_load,
  input  lfsr_t                   seed,
  lfsr_step_ctrl_if.master        q_if,
  output logic                    period_done,
  output logic                    overrun,
  output logic                    busy
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  ctrl_state_t      state_q;
  logic             busy_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             q_valid_q, q_valid_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic             period_done_q, period_done_d;
  lfsr_t            seed_reg_q, seed_reg_d;

  lfsr_t q;
  lfsr_t next_q;
  lfsr_t seed_eff;
  lfsr_t load_val;
  logic  seed_err;
  logic  lock_fix;
  logic  core_load;
  logic  tick;
  logic  accept;
  logic  step;
  logic  stall;

  lfsr_core #(
    .RESET_STATE (RESET_STATE)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (step),
    .load     (core_load),
    .load_val (load_val),
    .q        (q)
  );

  // NOTE: every signal assigned here gets a value on every path, so no
  // latches are inferred.
  always_comb begin
    tick   = (state_q == RUN) && (div_q == DIV_LAST);
    accept = q_valid_q && q_if.q_ready;
    // seed_load overrides everything, including a pending or due step.
    step   = !seed_load && (tick || pending_q) && (!q_valid_q || q_if.q_ready);
    stall  = !seed_load && tick && q_valid_q && !q_if.q_ready;

`ifdef LFSR_LOCKUP_RECOVER_EN
    seed_err = (seed == '0);
    seed_eff = seed_err ? RESET_STATE : seed;
    lock_fix = step && (q == '0);
    next_q   = (q == '0) ? RESET_STATE : lfsr_next(q);
`else
    seed_err = 1'b0;
    seed_eff = seed;
    lock_fix = 1'b0;
    next_q   = lfsr_next(q);
`endif

    core_load = seed_load || lock_fix;
    load_val  = seed_load ? seed_eff : RESET_STATE;

    seed_reg_d    = seed_load ? seed_eff : seed_reg_q;
    period_done_d = step && (next_q == seed_reg_q);

    q_valid_d = q_valid_q;
    if (seed_load)   q_valid_d = 1'b0;
    else if (step)   q_valid_d = 1'b1;
    else if (accept) q_valid_d = 1'b0;

    // step and stall are mutually exclusive (ready vs. !ready).
    pending_d = pending_q;
    if (seed_load || step)     pending_d = 1'b0;
    else if (stall)            pending_d = 1'b1;

    overrun_d = overrun_q;
    if (seed_load)                  overrun_d = seed_err;
    else if (stall && pending_q)    overrun_d = 1'b1;

    div_d = div_q;
    if (seed_load) begin
      div_d = '0;
    end else begin
      unique case (state_q)
        IDLE:    div_d = '0;
        RUN:     div_d = tick ? '0 : div_q + DIV_W'(1);
        PAUSE:   div_d = div_q;
        default: div_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else if (seed_load) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      // stop outranks start in every state.
      unique case (state_q)
        IDLE: if (start && !stop) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (stop) begin
          state_q <= PAUSE;
          busy_q  <= 1'b0;
        end
        PAUSE: if (start && !stop) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      q_valid_q     <= 1'b0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      period_done_q <= 1'b0;
      seed_reg_q    <= RESET_STATE;
    end else begin
      div_q         <= div_d;
      q_valid_q     <= q_valid_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      period_done_q <= period_done_d;
      seed_reg_q    <= seed_reg_d;
    end
  end

  assign q_if.q       = q;
  assign q_if.q_valid = q_valid_q;
  assign period_done  = period_done_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Self-checking bench for lfsr_step_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model of the controller.
module tb_lfsr_step_ctrl;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       seed_load;
  logic [4:0] seed;
  logic       period_done;
  logic       overrun;
  logic       busy;

  lfsr_step_ctrl_if q_if ();

  lfsr_step_ctrl #(
    .TICK_DIV (TD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .seed_load   (seed_load),
    .seed        (seed),
    .q_if        (q_if),
    .period_done (period_done),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: controller mode 0=idle 1=run 2=pause.
  int       m_mode;
  int       m_cnt;
  bit [4:0] m_q;
  bit [4:0] m_seed;
  bit       m_valid;
  bit       m_pend;
  bit       m_ovr;
  bit       m_pd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Polynomial x^5+x^3+1 written as integer arithmetic on the value.
  function automatic bit [4:0] succ(input bit [4:0] v);
    int x;
    int fb;
    x  = int'(v);
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (x == 0) return 5'd1;
`endif
    fb = (x ^ (x >> 2)) & 1;
    return 5'((x >> 1) + fb * 16);
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_cnt   = 0;
    m_q     = 5'd1;
    m_seed  = 5'd1;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_ovr   = 1'b0;
    m_pd    = 1'b0;
  endtask

  task automatic model_step();
    bit tick;
    bit go;
    bit rdy;
    if (reset) begin
      model_reset();
      return;
    end
    rdy  = q_if.q_ready;
    tick = (m_mode == 1) && (m_cnt == TD - 1);
    if (seed_load) begin
      m_q   = seed;
      m_ovr = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (seed == 5'd0) begin
        m_q   = 5'd1;
        m_ovr = 1'b1;
      end
`endif
      m_seed  = m_q;
      m_valid = 1'b0;
      m_pend  = 1'b0;
      m_cnt   = 0;
      m_mode  = 0;
      m_pd    = 1'b0;
      return;
    end
    go   = (tick || m_pend) && (!m_valid || rdy);
    m_pd = 1'b0;
    if (go) begin
      m_q     = succ(m_q);
      m_valid = 1'b1;
      m_pend  = 1'b0;
      m_pd    = (m_q == m_seed);
    end else begin
      if (tick && m_valid && !rdy) begin
        if (m_pend) m_ovr = 1'b1;
        else        m_pend = 1'b1;
      end
      if (m_valid && rdy) m_valid = 1'b0;
    end
    if (m_mode == 0)      m_cnt = 0;
    else if (m_mode == 1) m_cnt = (m_cnt + 1) % TD;
    case (m_mode)
      0: if (start && !stop) m_mode = 1;
      1: if (stop) m_mode = 2;
      2: if (start && !stop) m_mode = 1;
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    check("q",           q_if.q,       m_q);
    check("q_valid",     q_if.q_valid, m_valid);
    check("period_done", period_done,  m_pd);
    check("overrun",     overrun,      m_ovr);
    check("busy",        busy,         m_mode == 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  initial begin
    bit [4:0] exp_seq [4];
    bit [4:0] got [4];
    int       when [4];
    int       nval;
    int       pd_cnt;
    bit       seen;

    exp_seq[0] = 5'b10000;
    exp_seq[1] = 5'b01000;
    exp_seq[2] = 5'b00100;
    exp_seq[3] = 5'b10010;

    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    seed_load    = 1'b0;
    seed         = 5'd0;
    q_if.q_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    check("rst_q",       q_if.q,       5'b00001);
    check("rst_q_valid", q_if.q_valid, 1'b0);
    check("rst_pd",      period_done,  1'b0);
    check("rst_overrun", overrun,      1'b0);
    check("rst_busy",    busy,         1'b0);

    #10;
    reset        = 1'b0;
    start        = 1'b1;
    q_if.q_ready = 1'b1;

    // First four steps: fixed sequence, one step every TD cycles
    nval = 0;
    for (int c = 0; c < 40 && nval < 4; c++) begin
      cycle();
      if (q_if.q_valid) begin
        got[nval]  = q_if.q;
        when[nval] = c;
        nval++;
      end
    end
    check("p1_nsteps", nval, 4);
    for (int i = 0; i < 4; i++) check($sformatf("p1_seq%0d", i), got[i], exp_seq[i]);
    check("p1_first_lat", when[0], 4);
    for (int i = 1; i < 4; i++) check($sformatf("p1_gap%0d", i), when[i] - when[i-1], TD);

    // Complete the 31-state period
    pd_cnt = 0;
    repeat (27 * TD) begin
      cycle();
      if (period_done) pd_cnt++;
    end
    check("p2_pd_count", pd_cnt, 1);
    check("p2_pd_last",  period_done, 1'b1);
    check("p2_q_wrap",   q_if.q, 5'b00001);

    // Consumer stall: step, pending, then dropped tick
    cycle();
    q_if.q_ready = 1'b0;
    repeat (11) cycle();
    check("p3_overrun_set", overrun, 1'b1);
    q_if.q_ready = 1'b1;
    repeat (8) cycle();
    check("p3_overrun_sticky", overrun, 1'b1);

    // Pause holds q and divider, then resume
    start = 1'b0;
    stop  = 1'b1;
    repeat (10) cycle();
    check("p4_busy_pause", busy, 1'b0);
    stop  = 1'b0;
    start = 1'b1;
    repeat (2 * TD + 2) cycle();
    check("p4_busy_resume", busy, 1'b1);

    // seed_load while q_valid is high
    seen = 1'b0;
    for (int c = 0; c < 3 * TD && !seen; c++) begin
      cycle();
      seen = q_if.q_valid;
    end
    check("p5_valid_seen", seen, 1'b1);
    seed_load = 1'b1;
    seed      = 5'b10101;
    start     = 1'b0;
    cycle();
    seed_load = 1'b0;
    check("p5_q_seed",   q_if.q,       5'b10101);
    check("p5_valid0",   q_if.q_valid, 1'b0);
    check("p5_ovr_clr",  overrun,      1'b0);
    check("p5_idle",     busy,         1'b0);
    start  = 1'b1;
    nval   = 0;
    seen   = 1'b0;
    for (int c = 0; c < 31 * TD + 20 && !seen; c++) begin
      cycle();
      if (q_if.q_valid) nval++;
      seen = period_done;
    end
    check("p5_pd_seen",  seen,   1'b1);
    check("p5_steps",    nval,   31);
    check("p5_q_return", q_if.q, 5'b10101);

    // Random control and consumer behaviour
    for (int c = 0; c < 800; c++) begin
      start        = ($urandom % 4) == 0;
      stop         = ($urandom % 8) == 0;
      q_if.q_ready = ($urandom % 5) != 0;
      seed_load    = ($urandom % 64) == 0;
      seed         = 5'($urandom);
      cycle();
    end
    seed_load = 1'b0;

    // Zero seed
    seed_load    = 1'b1;
    seed         = 5'd0;
    start        = 1'b0;
    stop         = 1'b0;
    q_if.q_ready = 1'b1;
    cycle();
    seed_load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("p7_q_recover",   q_if.q,  5'b00001);
    check("p7_ovr_recover", overrun, 1'b1);
`else
    check("p7_q_zero",   q_if.q,  5'b00000);
    check("p7_ovr_zero", overrun, 1'b0);
`endif
    start  = 1'b1;
    nval   = 0;
    pd_cnt = 0;
    repeat (10 * TD) begin
      cycle();
      if (q_if.q_valid) nval++;
      if (period_done) pd_cnt++;
    end
`ifndef LFSR_LOCKUP_RECOVER_EN
    check("p7_pd_every_step", pd_cnt, nval);
    check("p7_steps",         nval,   9);
    check("p7_q_stuck",       q_if.q, 5'b00000);
`endif

    // Asynchronous reset mid-operation
    seed_load = 1'b1;
    seed      = 5'b00110;
    cycle();
    seed_load = 1'b0;
    repeat (3 * TD) cycle();
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("p8_rst_q",     q_if.q,       5'b00001);
    check("p8_rst_valid", q_if.q_valid, 1'b0);
    check("p8_rst_pd",    period_done,  1'b0);
    check("p8_rst_ovr",   overrun,      1'b0);
    check("p8_rst_busy",  busy,         1'b0);
    repeat (3) cycle();
    @(negedge clk);
    reset = 1'b0;
    repeat (6 * TD) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
